// File: rtl/mem_wr_pkg.sv
// mem_wr_pkg: store size codes, byte-enable patterns and the write-buffer entry type.
package mem_wr_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam int ENTRY_AW = 32;
  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [31:0]         data;
    logic [3:0]          be;
  } wr_entry_t;
endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: little-endian lane placement and byte enables for a store, plus misalignment flag.
module store_lane_align
  import mem_wr_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_data,
  input  logic [1:0]    i_size,
  output logic [AW-1:0] o_addr,
  output logic [31:0]   o_data,
  output logic [3:0]    o_be,
  output logic          o_misalign
);
  always_comb begin
    o_addr     = {i_addr[AW-1:2], 2'b00};
    o_data     = (i_size == SZ_BYTE) ? {4{i_data[7:0]}} :
                 (i_size == SZ_HALF) ? {2{i_data[15:0]}} : i_data;
    o_be       = (i_size == SZ_BYTE) ? BE_BYTE << i_addr[1:0] :
                 (i_size == SZ_HALF) ? (i_addr[1] ? BE_HI : BE_LO) : BE_WORD;
    o_misalign = (i_size == SZ_RSVD) | ((i_size == SZ_HALF) & i_addr[0]) |
                 ((i_size == SZ_WORD) & (|i_addr[1:0]));
  end
endmodule

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: aligns MEM-stage stores and queues them in a show-ahead FIFO draining over valid/ready.
// MEM_WR_HAZARD_EN adds MemRead/LoadHazard for read-after-write protection against pending entries.
module mem_write_buffer
  import mem_wr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          MemWrite,
  input  logic [AW-1:0] Address,
  input  logic [31:0]   WriteData,
  input  logic [1:0]    StoreSize,
`ifdef MEM_WR_HAZARD_EN
  input  logic          MemRead,
  output logic          LoadHazard,
`endif
  output logic          Stall,
  output logic          AlignErr,
  output logic          Empty,
  output logic          MemWrValid,
  output logic [AW-1:0] MemWrAddr,
  output logic [31:0]   MemWrData,
  output logic [3:0]    MemWrBe,
  input  logic          MemWrReady
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_align_err;
  wr_entry_t     r_mem [DEPTH];

  logic [AW-1:0] w_al_addr;
  logic [31:0]   w_al_data;
  logic [3:0]    w_al_be;
  logic          w_misalign, w_full, w_pop, w_push;
  wr_entry_t     w_entry, w_head;

  store_lane_align #(.AW(AW)) u_align (
    .i_addr     (Address),
    .i_data     (WriteData),
    .i_size     (StoreSize),
    .o_addr     (w_al_addr),
    .o_data     (w_al_data),
    .o_be       (w_al_be),
    .o_misalign (w_misalign)
  );

  // A pop in the same cycle frees a slot, so a full buffer still accepts (pass-through).
  always_comb begin
    w_full     = r_count == CW'(DEPTH);
    MemWrValid = r_count != '0;
    Empty      = r_count == '0;
    w_pop      = MemWrValid & MemWrReady;
    w_push     = MemWrite & ~w_misalign & (~w_full | w_pop);
    Stall      = MemWrite & ~w_misalign & w_full & ~w_pop;
    AlignErr   = r_align_err;
    w_entry    = '{addr: ENTRY_AW'(w_al_addr), data: w_al_data, be: w_al_be};
    w_head     = r_mem[r_rd_ptr];
    MemWrAddr  = MemWrValid ? AW'(w_head.addr) : '0;
    MemWrData  = MemWrValid ? w_head.data : '0;
    MemWrBe    = MemWrValid ? w_head.be : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= MemWrite & w_misalign;
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

`ifdef MEM_WR_HAZARD_EN
  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    LoadHazard = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      LoadHazard = LoadHazard | (MemRead & ({1'b0, PW'(i) - r_rd_ptr} < r_count) &
                   (r_mem[i].addr[AW-1:2] == Address[AW-1:2]));
  end
`endif
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: randomized scoreboard bench with a queue-based reference model of the write buffer.
module tb_mem_write_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } beat_t;

  logic        clk, rst_n, MemWrite, MemWrReady;
  logic [31:0] Address, WriteData;
  logic [1:0]  StoreSize;
  logic        Stall, AlignErr, Empty, MemWrValid;
  logic [31:0] MemWrAddr, MemWrData;
  logic [3:0]  MemWrBe;
`ifdef MEM_WR_HAZARD_EN
  logic        MemRead, LoadHazard;
`endif

  int    n_tests = 0, n_fail = 0;
  beat_t exp_q[$];
  bit    exp_err = 0;
  bit    acc;

  mem_write_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .WriteData  (WriteData),
    .StoreSize  (StoreSize),
`ifdef MEM_WR_HAZARD_EN
    .MemRead    (MemRead),
    .LoadHazard (LoadHazard),
`endif
    .Stall      (Stall),
    .AlignErr   (AlignErr),
    .Empty      (Empty),
    .MemWrValid (MemWrValid),
    .MemWrAddr  (MemWrAddr),
    .MemWrData  (MemWrData),
    .MemWrBe    (MemWrBe),
    .MemWrReady (MemWrReady)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : s == 2'd2 ? 4 : 0;
  endfunction

  function automatic bit aligned(input logic [31:0] a, input logic [1:0] s);
    int n = nbytes(s);
    return n != 0 && (a % n) == 0;
  endfunction

  function automatic beat_t model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    beat_t b;
    int n = nbytes(s);
    b.a  = a - (a % 4);
    b.be = 4'(((1 << n) - 1) << (a % 4));
    b.d  = n == 1 ? (d & 32'hFF) * 32'h01010101 : n == 2 ? (d & 32'hFFFF) * 32'h00010001 : d;
    return b;
  endfunction

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input bit rdy, input bit rd, output bit accepted);
    bit pop, al, st, hz;
    MemWrite = w; Address = a; WriteData = d; StoreSize = s; MemWrReady = rdy;
`ifdef MEM_WR_HAZARD_EN
    MemRead = rd;
`endif
    #1;
    al  = aligned(a, s);
    pop = rdy && exp_q.size() != 0;
    st  = w && al && exp_q.size() == DEPTH && !pop;
    chk("stall", Stall, st);
    chk("align_err", AlignErr, exp_err);
    hz = 0;
    foreach (exp_q[i]) if (exp_q[i].a[31:2] == a[31:2]) hz = rd;
`ifdef MEM_WR_HAZARD_EN
    chk("load_hazard", LoadHazard, hz);
`endif
    accepted = w && al && !st;
    @(posedge clk);
    if (accepted) exp_q.push_back(model(a, d, s));
    exp_err = w && !al;
    #1;
  endtask

  task automatic drain();
    bit a;
    int k = 0;
    while ((exp_q.size() != 0 || MemWrValid) && k < 50) begin
      step(0, 0, 0, 0, 1, 0, a);
      k++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Monitor: the head must match the oldest expected store whenever valid.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", MemWrValid, exp_q.size() != 0);
      chk("empty", Empty, exp_q.size() == 0);
      if (MemWrValid && exp_q.size() != 0) begin
        chk("head_addr", MemWrAddr, exp_q[0].a);
        chk("head_data", MemWrData, exp_q[0].d);
        chk("head_be", MemWrBe, exp_q[0].be);
        if (MemWrReady) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  s;
    bit          w, rd;
    int          tries;
    rst_n = 0; MemWrite = 0; Address = 0; WriteData = 0; StoreSize = 0; MemWrReady = 0;
`ifdef MEM_WR_HAZARD_EN
    MemRead = 0;
`endif
    #3;
    chk("rst_valid", MemWrValid, 0);
    chk("rst_empty", Empty, 1);
    chk("rst_stall", Stall, 0);
    chk("rst_alignerr", AlignErr, 0);
    chk("rst_addr", MemWrAddr, 0);
    chk("rst_data", MemWrData, 0);
    chk("rst_be", MemWrBe, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    step(1, 32'h100, 32'hDEADBEEF, 2'b10, 1, 0, acc);
    chk("word_addr", MemWrAddr, 32'h100);
    chk("word_data", MemWrData, 32'hDEADBEEF);
    chk("word_be", MemWrBe, 4'b1111);
    step(0, 0, 0, 0, 1, 0, acc);
    chk("word_drained", Empty, 1);

    step(1, 32'h203, 32'h000000AB, 2'b00, 0, 0, acc);
    chk("byte_addr", MemWrAddr, 32'h200);
    chk("byte_be", MemWrBe, 4'b1000);
    chk("byte_lane", MemWrData[31:24], 8'hAB);
    drain();

    step(1, 32'h302, 32'h00001234, 2'b01, 0, 0, acc);
    chk("half_be", MemWrBe, 4'b1100);
    chk("half_lane", MemWrData[31:16], 16'h1234);
    drain();

    step(1, 32'h301, 32'h5555, 2'b01, 0, 0, acc);
    chk("mis_pulse", AlignErr, 1);
    chk("mis_empty", Empty, 1);
    step(1, 32'h300, 32'h5555, 2'b11, 0, 0, acc);
    chk("rsvd_pulse", AlignErr, 1);
    step(0, 0, 0, 0, 0, 0, acc);
    chk("pulse_end", AlignErr, 0);
    chk("rsvd_empty", Empty, 1);

    for (int i = 0; i < 4; i++) begin
      step(1, 32'h500 + 4 * i, 32'h1000 + i, 2'b10, 0, 0, acc);
      chk("fill_acc", acc, 1);
    end
    step(1, 32'h510, 32'h1004, 2'b10, 0, 0, acc);
    chk("fifth_stalled", acc, 0);
    chk("fifth_stall_hold", Stall, 1);
    step(1, 32'h510, 32'h1004, 2'b10, 1, 0, acc);
    chk("pass_through", acc, 1);
    drain();

    for (int i = 0; i < 3; i++) step(1, 32'h600 + 4 * i, $urandom, 2'b10, 0, 0, acc);
    MemWrite = 0;
    rst_n = 0;
    exp_q.delete();
    exp_err = 0;
    #1;
    chk("mid_rst_valid", MemWrValid, 0);
    chk("mid_rst_empty", Empty, 1);
    chk("mid_rst_be", MemWrBe, 0);
    @(posedge clk);
    #1 rst_n = 1;
    step(0, 0, 0, 0, 1, 0, acc);
    chk("post_rst_empty", Empty, 1);

`ifdef MEM_WR_HAZARD_EN
    step(1, 32'h400, 32'h77, 2'b10, 0, 0, acc);
    step(0, 32'h402, 0, 2'b01, 0, 1, acc);
    chk("hazard_hit", LoadHazard, 1);
    drain();
    step(0, 32'h402, 0, 2'b01, 0, 1, acc);
    chk("hazard_clear", LoadHazard, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      w  = $urandom_range(0, 3) != 0;
      s  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'h400 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      d  = $urandom;
      rd = 1'($urandom_range(0, 1));
      tries = 0;
      do begin
        step(w, a, d, s, 1'($urandom_range(0, 1)), rd, acc);
        tries++;
      end while (w && aligned(a, s) && !acc && tries < 100);
      if (w && aligned(a, s)) chk("rand_accept", acc, 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
